// File: rtl/routex_pkg.sv
// Shared types and constants for the routex ingress path: the 8-lane beat,
// the header length field location, and the arbiter state encoding.
package routex_pkg;

  localparam int LANES      = 8;
  localparam int LEN_LANE   = 7;
  localparam int LEN_W      = 16;
  localparam int BEAT_CNT_W = 14;

  typedef logic [LANES-1:0][63:0] beat_t;

  typedef enum logic [3:0] {
    HOP_LOCAL = 4'h0,
    HOP_NORTH = 4'h1,
    HOP_SOUTH = 4'h2,
    HOP_EAST  = 4'h3,
    HOP_WEST  = 4'h4,
    HOP_DROP  = 4'hF
  } hop_type_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } arb_state_t;

  // Body beats following a header: ceil(LEN/8); LEN=65535 still fits in 14 bits.
  function automatic logic [BEAT_CNT_W-1:0] body_beats(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'(7);
    return sum[LEN_W:3];
  endfunction

endpackage

// File: rtl/routex_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above i_ptr,
// wrapping modulo N. Returns one-hot and binary winner plus a found flag.
module routex_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [PW-1:0] o_idx,
  output logic          o_found
);

  // Scan from farthest to nearest so the last hit is the closest to the pointer.
  always_comb begin
    int idx;
    idx      = 0;
    o_onehot = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(i_ptr) + k) % N;
      if (i_req[idx]) begin
        o_onehot = N'(1) << idx;
        o_idx    = PW'(idx);
        o_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/routex_fifo_arb.sv
// Packet-granular round-robin arbiter feeding one FWFT FIFO write port.
// Optional stall watchdog enabled by defining ROUTEX_ARB_WDOG_EN.
module routex_fifo_arb
  import routex_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  beat_t [N_SRC-1:0]    i_s_d,
  input  logic  [N_SRC-1:0]    i_s_valid,
  output logic  [N_SRC-1:0]    o_s_bp,
  output beat_t                o_fifo_d,
  output logic                 o_fifo_we,
  output logic                 o_fifo_eop,
  input  logic                 i_fifo_pfull,
  output logic  [N_SRC-1:0]    o_grant,
  output arb_state_t           o_dbg_state
`ifdef ROUTEX_ARB_WDOG_EN
  ,
  output logic                 o_stall_err
`endif
);

  localparam int PW = $clog2(N_SRC);

  if (N_SRC < 2 || N_SRC > 8 || WDOG_CYCLES < 1) begin : g_bad_cfg
    $error("routex_fifo_arb: N_SRC must be 2..8 and WDOG_CYCLES >= 1");
  end

  arb_state_t            r_state, w_state_nxt;
  logic [PW-1:0]         r_ptr, w_ptr_nxt;
  logic [PW-1:0]         r_owner, w_owner_nxt;
  logic [N_SRC-1:0]      r_grant, w_grant_nxt;
  logic [BEAT_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [BEAT_CNT_W-1:0] w_beats;
  logic [N_SRC-1:0]      w_pick_oh, w_bp;
  logic [PW-1:0]         w_pick_idx, w_sel;
  logic                  w_pick_found, w_xfer, w_eop;
  beat_t                 r_fifo_d;
  logic                  r_fifo_we, r_fifo_eop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (int'(p) == N_SRC - 1) ? '0 : p + 1'b1;
  endfunction

  routex_rr_pick #(.N(N_SRC), .PW(PW)) u_pick (
    .i_req    (i_s_valid),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_found  (w_pick_found)
  );

  assign w_beats = body_beats(i_s_d[w_pick_idx][LEN_LANE][LEN_W-1:0]);

  // Handshake: a beat moves from source i when i_s_valid[i] && !o_s_bp[i];
  // sources hold data and valid while backpressured.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    w_bp        = '1;
    w_sel       = r_owner;
    w_xfer      = 1'b0;
    w_eop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_sel = w_pick_idx;
        if (!i_fifo_pfull && w_pick_found) begin
          w_bp   = ~w_pick_oh;
          w_xfer = 1'b1;
          if (w_beats == '0) begin
            w_eop     = 1'b1;
            w_ptr_nxt = next_ptr(w_pick_idx);
          end else begin
            w_state_nxt = ST_BODY;
            w_grant_nxt = w_pick_oh;
            w_owner_nxt = w_pick_idx;
            w_cnt_nxt   = w_beats;
          end
        end
      end
      ST_BODY: begin
        w_bp = ~r_grant | {N_SRC{i_fifo_pfull}};
        if (i_s_valid[r_owner] && !i_fifo_pfull) begin
          w_xfer    = 1'b1;
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == BEAT_CNT_W'(1)) begin
            w_eop       = 1'b1;
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_ptr_nxt   = next_ptr(r_owner);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_grant    <= '0;
      r_cnt      <= '0;
      r_fifo_d   <= '0;
      r_fifo_we  <= 1'b0;
      r_fifo_eop <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_grant    <= w_grant_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fifo_we  <= w_xfer;
      r_fifo_eop <= w_xfer & w_eop;
      if (w_xfer) r_fifo_d <= i_s_d[w_sel];
    end
  end

  // Reset forces backpressure even though the picker would otherwise open a port.
  assign o_s_bp      = w_bp | {N_SRC{i_rst}};
  assign o_fifo_d    = r_fifo_d;
  assign o_fifo_we   = r_fifo_we;
  assign o_fifo_eop  = r_fifo_eop;
  assign o_grant     = r_grant;
  assign o_dbg_state = r_state;

`ifdef ROUTEX_ARB_WDOG_EN
  logic [15:0] r_wdog;
  logic        r_stall_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wdog      <= '0;
      r_stall_err <= 1'b0;
    end else if (w_xfer) begin
      r_wdog <= '0;
    end else if (r_state == ST_BODY && !i_s_valid[r_owner]) begin
      if (r_wdog != '1) r_wdog <= r_wdog + 1'b1;
      if (int'(r_wdog) + 1 >= WDOG_CYCLES) r_stall_err <= 1'b1;
    end
  end

  assign o_stall_err = r_stall_err;
`endif

endmodule

// File: tb/tb_routex_fifo_arb.sv
// Directed bench for routex_fifo_arb: packet-level reference arbiter, per-cycle
// compare of backpressure/grant/writes, and literal checks on order and counts.
module tb_routex_fifo_arb;
  import routex_pkg::*;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst;
  beat_t [N-1:0]       s_d;
  logic  [N-1:0]       s_valid;
  logic  [N-1:0]       s_bp;
  beat_t               fifo_d;
  logic                fifo_we, fifo_eop, pfull;
  logic  [N-1:0]       grant;
  arb_state_t          dbg_state;
`ifdef ROUTEX_ARB_WDOG_EN
  logic                stall_err;
`endif

  always #5 clk = ~clk;

  routex_fifo_arb #(.N_SRC(N), .WDOG_CYCLES(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_s_d        (s_d),
    .i_s_valid    (s_valid),
    .o_s_bp       (s_bp),
    .o_fifo_d     (fifo_d),
    .o_fifo_we    (fifo_we),
    .o_fifo_eop   (fifo_eop),
    .i_fifo_pfull (pfull),
    .o_grant      (grant),
    .o_dbg_state  (dbg_state)
`ifdef ROUTEX_ARB_WDOG_EN
    ,
    .o_stall_err  (stall_err)
`endif
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  beat_t       src_q[N][$];
  logic        hold[N];
  logic        pfull_cfg;
  logic [512:0] exp_q[$];

  // Reference arbiter state: owner (-1 idle), remaining body beats, pointer.
  int          m_owner, m_rem, m_ptr;

  int          cyc, n_wr, n_eop, n_gnt, n_wr_win, first_wr, last_wr;
  logic        win;
  string       hdr_str;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_beat(input string name, input logic [512:0] act, input logic [512:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
  endtask

  task automatic add_pkt(input int src, input int len);
    beat_t b;
    for (int l = 0; l < LANES; l++) b[l] = {$urandom(), $urandom()};
    b[0]        = 64'hA0 + 64'(src);
    b[7][15:0]  = 16'(len);
    src_q[src].push_back(b);
    for (int k = 0; k < (len + 7) / 8; k++) begin
      for (int l = 0; l < LANES; l++) b[l] = {$urandom(), $urandom()};
      b[0] = 64'hB0 + 64'(src);
      src_q[src].push_back(b);
    end
  endtask

  task automatic reset_stats();
    n_wr = 0; n_eop = 0; n_gnt = 0; n_wr_win = 0;
    first_wr = 0; last_wr = 0; hdr_str = "";
  endtask

  function automatic logic busy();
    logic any;
    any = (m_owner >= 0);
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) any = 1'b1;
    return any;
  endfunction

  // One clock: drive sources, predict, compare backpressure, then registered outputs.
  task automatic do_cycle();
    logic [N-1:0] m_bp, m_gnt;
    int           m_src, len, beats;
    logic         m_eop;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        s_valid[i] = !hold[i];
        s_d[i]     = src_q[i][0];
      end else begin
        s_valid[i] = 1'b0;
        s_d[i]     = '0;
      end
    end
    pfull = pfull_cfg;
    #1;
    m_bp = '1; m_src = -1; m_eop = 1'b0;
    if (m_owner < 0) begin
      if (!pfull) begin
        for (int k = 0; k < N; k++) begin
          if (m_src < 0 && s_valid[(m_ptr + k) % N]) m_src = (m_ptr + k) % N;
        end
      end
      if (m_src >= 0) begin
        m_bp[m_src] = 1'b0;
        len   = int'(src_q[m_src][0][7][15:0]);
        beats = (len + 7) / 8;
        if (beats == 0) begin
          m_eop = 1'b1;
          m_ptr = (m_src + 1) % N;
        end else begin
          m_owner = m_src;
          m_rem   = beats;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) m_bp[i] = (i != m_owner) || pfull;
      if (s_valid[m_owner] && !pfull) begin
        m_src = m_owner;
        m_rem--;
        if (m_rem == 0) begin
          m_eop   = 1'b1;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end
    chk("s_bp", 64'(s_bp), 64'(m_bp));
    if (m_src >= 0) begin
      exp_q.push_back({m_eop, src_q[m_src][0]});
      void'(src_q[m_src].pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
    m_gnt = '0;
    if (m_owner >= 0) m_gnt[m_owner] = 1'b1;
    chk("fifo_we", 64'(fifo_we), 64'(m_src >= 0));
    chk("grant", 64'(grant), 64'(m_gnt));
    if (fifo_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard: write with nothing expected (cycle %0d)", cyc);
      end else begin
        chk_beat("fifo_beat", {fifo_eop, fifo_d}, exp_q.pop_front());
      end
      if (n_wr == 0) first_wr = cyc;
      last_wr = cyc;
      n_wr++;
      if (fifo_eop) n_eop++;
      if (win) n_wr_win++;
      if (fifo_d[0][7:4] == 4'hA) hdr_str = {hdr_str, $sformatf("%0d", fifo_d[0][3:0])};
    end
    exp_q.delete();
    if (grant != '0) n_gnt++;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) do_cycle();
  endtask

  task automatic run_until_idle();
    int g;
    g = 0;
    while (busy() && g < 300) begin
      do_cycle();
      g++;
    end
    if (busy()) begin
      n_checks++;
      $display("FAIL timeout: arbiter still busy after %0d cycles", g);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bp"},    64'(s_bp), 64'(4'hF));
    chk({tag, "_we"},    64'(fifo_we), 64'(0));
    chk({tag, "_eop"},   64'(fifo_eop), 64'(0));
    chk({tag, "_grant"}, 64'(grant), 64'(0));
    chk_beat({tag, "_d"}, {1'b0, fifo_d}, '0);
  endtask

  initial begin
    rst = 1'b1; s_valid = '1; s_d = '0; pfull = 1'b0; pfull_cfg = 1'b0; win = 1'b0;
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    m_owner = -1; m_rem = 0; m_ptr = 0; cyc = 0;
    reset_stats();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("rst_init");
    rst = 1'b0; s_valid = '0;

    // All four sources contend with LEN=8: order 0,1,2,3,0 back to back.
    reset_stats();
    add_pkt(0, 8); add_pkt(1, 8); add_pkt(2, 8); add_pkt(3, 8); add_pkt(0, 8);
    run_until_idle();
    chk_str("rr_order", hdr_str, "01230");
    chk("rr_writes", 64'(n_wr), 64'(10));
    chk("rr_span", 64'(last_wr - first_wr + 1), 64'(10));

    // LEN=10 from src0: header + 2 body beats.
    reset_stats();
    add_pkt(0, 10);
    run_until_idle();
    chk("t1_writes", 64'(n_wr), 64'(3));
    chk("t1_span", 64'(last_wr - first_wr + 1), 64'(3));
    chk("t1_eops", 64'(n_eop), 64'(1));
    chk("t1_grant_cycles", 64'(n_gnt), 64'(2));

    // Header-only packet from src2, then src0 and src3 contend: pointer is at 3.
    reset_stats();
    add_pkt(2, 0);
    run_until_idle();
    chk("t3_writes", 64'(n_wr), 64'(1));
    chk("t3_eops", 64'(n_eop), 64'(1));
    chk("t3_grant_cycles", 64'(n_gnt), 64'(0));
    reset_stats();
    add_pkt(0, 8); add_pkt(3, 8);
    run_until_idle();
    chk_str("t3_ptr_order", hdr_str, "30");

    // Prog-full for 5 cycles mid-body of src1 while src2 waits.
    reset_stats();
    add_pkt(1, 40); add_pkt(2, 8);
    run_cycles(2);
    pfull_cfg = 1'b1; win = 1'b1;
    run_cycles(5);
    pfull_cfg = 1'b0; win = 1'b0;
    run_until_idle();
    chk("t4_pfull_writes", 64'(n_wr_win), 64'(0));
    chk("t4_writes", 64'(n_wr), 64'(8));
    chk_str("t4_order", hdr_str, "12");

    // Owner src3 drops valid for 3 cycles while src1 is waiting.
    reset_stats();
    add_pkt(3, 24); add_pkt(1, 8);
    run_cycles(2);
    hold[3] = 1'b1; win = 1'b1;
    run_cycles(3);
    hold[3] = 1'b0; win = 1'b0;
    run_until_idle();
    chk("t5_gap_writes", 64'(n_wr_win), 64'(0));
    chk("t5_writes", 64'(n_wr), 64'(6));
    chk_str("t5_order", hdr_str, "31");

`ifdef ROUTEX_ARB_WDOG_EN
    // Eight consecutive stall cycles with WDOG_CYCLES=8 raise the sticky flag.
    reset_stats();
    add_pkt(2, 8);
    run_cycles(1);
    hold[2] = 1'b1;
    run_cycles(7);
    chk("wdog_before", 64'(stall_err), 64'(0));
    run_cycles(1);
    chk("wdog_after", 64'(stall_err), 64'(1));
    hold[2] = 1'b0;
    run_until_idle();
    chk("wdog_sticky", 64'(stall_err), 64'(1));
`endif

    // Reset in the middle of a long src0 packet.
    reset_stats();
    add_pkt(0, 64); add_pkt(2, 8);
    run_cycles(3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    check_reset_outputs("rst_edge");
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    m_owner = -1; m_rem = 0; m_ptr = 0;
    @(negedge clk);
    rst = 1'b0; s_valid = '0;
    reset_stats();
    add_pkt(1, 8); add_pkt(0, 8);
    run_until_idle();
    chk_str("t6_restart_order", hdr_str, "01");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
